hdmi_timing_720p: RTL and testbench
===================================

# hdmi_timing_720p

Video timing generator for the HDMI output path, clocked by the 74.25 MHz pixel clock produced by the HDMI PLL (which also provides the 5x TMDS serial clock). It produces CEA-861 1280x720@60 sync and data-enable signals. It also produces a 3x integer-scaled source window, 256x224 scaled to 768x672 and centred, with source pixel coordinates and line-prefetch requests for the framebuffer line buffer. Its outputs feed the TMDS encoder/serializer stage.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch (H_TOTAL = 1650)
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync lines
- V_BP, 20, vertical back porch (V_TOTAL = 750)
- X_OFFSET, 256, first window column
- Y_OFFSET, 24, first window line
- SRC_W, 256, source width
- SRC_H, 224, source height
- PREFETCH, 16, cycles before X_OFFSET at which `fetch` pulses

Ports:
- clk_pixel  in  1  pixel clock, 74.25 MHz
- resetn  in  1  asynchronous active-low reset
- enable  in  1  advance timing when high
- hcnt  out  11  current column, 0..H_TOTAL-1
- vcnt  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- de  out  1  active video
- frame_start  out  1  one-cycle pulse at position (0,0)
- win  out  1  position inside the scaled source window
- src_x  out  8  source column (valid when win)
- src_y  out  8  source row (valid when win)
- fetch  out  1  one-cycle line-prefetch request
- fetch_y  out  8  source row to prefetch (valid with fetch)

## Operation
- Reset clocking: one clock; reset is asynchronous and active-low.
- Reset values: every output 0. Internal position is (0,0); sub-counters and source counters are 0.
- Position (h,v):
  - Advances on each edge with enable=1.
  - h wraps at H_TOTAL-1 to 0, and v increments on that wrap.
  - v wraps at V_TOTAL-1 to 0.
- Derived signals, all referring to the same position as hcnt/vcnt:
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hsync = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); this is 1390..1429.
  - vsync = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for whole lines; this is 725..729.
  - frame_start = (h,v)==(0,0).
- Window: win = h in [X_OFFSET, X_OFFSET+3*SRC_W) && v in [Y_OFFSET, Y_OFFSET+3*SRC_H).
- Horizontal scaling:
  - sub_x (0..2) and src_x clear when h==X_OFFSET.
  - Within the window, sub_x increments; on wrap 2->0, src_x increments.
  - src_x never exceeds SRC_W-1.
- Vertical scaling:
  - sub_y/src_y clear at v==Y_OFFSET, h==0.
  - At h==H_TOTAL-1 on a window line, sub_y advances, and src_y increments on wrap.
- Prefetch:
  - fetch=1 for exactly one cycle at h==X_OFFSET-PREFETCH on window lines with sub_y==0.
  - fetch_y = src_y of that line.
  - This gives exactly SRC_H fetches per frame.
- Enable low:
  - Position and sub/source counters hold.
  - de, hsync, vsync, win, frame_start and fetch are forced to 0 from the next edge.
  - When enable returns high, timing resumes from the held position.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The first enabled edge after release restarts at (0,0).

## Timing
- All outputs are registered and mutually aligned. There is no combinational path from enable to outputs.
- The first enabled edge after resetn rises presents position (0,0): frame_start=1, de=1, hcnt=0, vcnt=0.
- Per frame: 1,237,500 cycles between frame_start pulses, and 921,600 de cycles.
- Per active line: de is high for 1280 consecutive cycles and hsync for 40.
- Window lines: win is high for 768 consecutive cycles. Each src_x value is held for 3 cycles, and each src_y value for 3 lines.
- Required by the consumer: PREFETCH < X_OFFSET, and the line buffer returns data within PREFETCH cycles.

## Structure
- Package `video_timing_pkg`: 720p constants (H_/V_ totals and porches), scale factor 3, and coordinate widths.
- Sub-module `scale3_counter`: divide-by-3 sub-counter plus source counter with clear/advance inputs. It is instantiated twice, once for x (advanced per pixel) and once for y (advanced per line).

## Test plan
- Reset release with enable=1 -> first cycle shows hcnt=0, vcnt=0, frame_start=1, de=1. The next frame_start comes 1,237,500 cycles later.
- One full frame -> 921,600 de cycles; hsync 1390..1429 on every line; vsync high on exactly lines 725..729.
- Line v=24:
  - win rises at h=256 and falls at h=1024.
  - src_x is 0 on h=256..258, 1 on h=259, and 255 on h=1021..1023.
- Fetch over one frame:
  - Exactly 224 fetch pulses.
  - First at v=24, h=240, fetch_y=0; then v=27 with fetch_y=1; last at v=693 with fetch_y=223.
- Enable low for 100 cycles at (500,300) -> de=0 and hcnt=500 held. After re-enable, de=1 with hcnt=500 on the first enabled output, and the frame length grows by exactly 100.
- resetn pulsed low at (800,400) -> all outputs 0 immediately. After release, restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants for the HDMI video timing path.
//
// Holds the CEA-861 1280x720@60 line/frame geometry, the integer scale
// factor used for the centred source window, and the widths of the
// position and source-coordinate buses. Timing blocks import this package
// so that every stage agrees on the same numbers.
//
// Contents:
//   H_W / V_W       widths of the horizontal / vertical position counters
//   SRC_BITS        width of a source pixel coordinate
//   SUB_W           width of the divide-by-SCALE phase counter
//   SCALE           integer upscale factor of the source window
//   *_720           720p active/porch/sync geometry
//   scaled_extent   size of a source dimension once scaled to the output
package video_timing_pkg;

   localparam int H_W      = 11;
   localparam int V_W      = 10;
   localparam int SRC_BITS = 8;
   localparam int SUB_W    = 2;

   localparam int SCALE = 3;

   localparam int H_ACTIVE_720 = 1280;
   localparam int H_FP_720     = 110;
   localparam int H_SYNC_720   = 40;
   localparam int H_BP_720     = 220;
   localparam int H_TOTAL_720  = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;

   localparam int V_ACTIVE_720 = 720;
   localparam int V_FP_720     = 5;
   localparam int V_SYNC_720   = 5;
   localparam int V_BP_720     = 20;
   localparam int V_TOTAL_720  = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

   // Number of output pixels (or lines) covered by src source units.
   function automatic int scaled_extent(input int src);
      return SCALE * src;
   endfunction

endpackage

// File: rtl/scale3_counter.sv
// Divide-by-SCALE phase counter feeding a saturating source counter.
//
// Every 'advance' steps the phase 'sub' through 0..SCALE-1; when the phase
// wraps, the source coordinate 'src' moves on by one, so each source value
// is held for SCALE advances. 'src' stops at SRC_MAX so an extra advance at
// the end of the window cannot wrap it back to 0. 'clear' wins over
// 'advance'.
//
// Ports:
//   clk_pixel  in   pixel clock
//   resetn     in   asynchronous active-low reset
//   clear      in   return sub and src to 0 on the next edge
//   advance    in   step the phase (and the source coordinate on wrap)
//   sub        out  current phase, 0..SCALE-1
//   src        out  current source coordinate, 0..SRC_MAX
module scale3_counter
   import video_timing_pkg::*;
#(
   parameter int SRC_MAX = 255
)
(
   input  logic                clk_pixel,
   input  logic                resetn,
   input  logic                clear,
   input  logic                advance,
   output logic [SUB_W-1:0]    sub,
   output logic [SRC_BITS-1:0] src
);

   localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(SCALE - 1);
   localparam logic [SRC_BITS-1:0] SRC_LAST = SRC_BITS'(SRC_MAX);

   // Phase/source counter: once both are at their last value the counter
   // parks there until the next clear.
   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         sub <= '0;
         src <= '0;
      end else if (clear) begin
         sub <= '0;
         src <= '0;
      end else if (advance) begin
         if (sub != SUB_LAST) begin
            sub <= sub + 1'b1;
         end else if (src != SRC_LAST) begin
            sub <= '0;
            src <= src + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hdmi_timing_720p.sv
// Video timing generator for the HDMI output path (1280x720@60).
//
// Walks a (h,v) raster position at the pixel clock and registers sync,
// data-enable and a 3x-scaled centred source window, together with the
// source pixel coordinates and a once-per-source-line prefetch request for
// the framebuffer line buffer. Every output describes the same position as
// hcnt/vcnt on the same cycle.
//
// Ports:
//   clk_pixel    in   74.25 MHz pixel clock
//   resetn       in   asynchronous active-low reset
//   enable       in   advance the raster when high
//   hcnt         out  current column, 0..H_TOTAL-1
//   vcnt         out  current line, 0..V_TOTAL-1
//   hsync        out  active-high horizontal sync
//   vsync        out  active-high vertical sync
//   de           out  active video
//   frame_start  out  one-cycle pulse at position (0,0)
//   win          out  position inside the scaled source window
//   src_x        out  source column (valid with win)
//   src_y        out  source row (valid with win)
//   fetch        out  one-cycle line-prefetch request
//   fetch_y      out  source row to prefetch (valid with fetch)
//
// The line buffer must answer within PREFETCH cycles, and PREFETCH must be
// smaller than X_OFFSET so the request lands on the same line.
module hdmi_timing_720p
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_720,
   parameter int H_FP     = H_FP_720,
   parameter int H_SYNC   = H_SYNC_720,
   parameter int H_BP     = H_BP_720,
   parameter int V_ACTIVE = V_ACTIVE_720,
   parameter int V_FP     = V_FP_720,
   parameter int V_SYNC   = V_SYNC_720,
   parameter int V_BP     = V_BP_720,
   parameter int X_OFFSET = 256,
   parameter int Y_OFFSET = 24,
   parameter int SRC_W    = 256,
   parameter int SRC_H    = 224,
   parameter int PREFETCH = 16
)
(
   input  logic                clk_pixel,
   input  logic                resetn,
   input  logic                enable,
   output logic [H_W-1:0]      hcnt,
   output logic [V_W-1:0]      vcnt,
   output logic                hsync,
   output logic                vsync,
   output logic                de,
   output logic                frame_start,
   output logic                win,
   output logic [SRC_BITS-1:0] src_x,
   output logic [SRC_BITS-1:0] src_y,
   output logic                fetch,
   output logic [SRC_BITS-1:0] fetch_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_W-1:0] X_START  = H_W'(X_OFFSET);
   localparam logic [H_W-1:0] X_END    = H_W'(X_OFFSET + scaled_extent(SRC_W));
   localparam logic [H_W-1:0] FETCH_H  = H_W'(X_OFFSET - PREFETCH);

   localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0] Y_START  = V_W'(Y_OFFSET);
   localparam logic [V_W-1:0] Y_END    = V_W'(Y_OFFSET + scaled_extent(SRC_H));

   logic [H_W-1:0]      h;
   logic [H_W-1:0]      h_next;
   logic [V_W-1:0]      v;
   logic [V_W-1:0]      v_next;
   logic [SUB_W-1:0]    x_sub;
   logic [SRC_BITS-1:0] x_src;
   logic [SUB_W-1:0]    y_sub;
   logic [SRC_BITS-1:0] y_src;
   logic                de_c;
   logic                hs_c;
   logic                vs_c;
   logic                fs_c;
   logic                win_h;
   logic                win_v;
   logic                fetch_c;
   logic                unused_x_sub;

   // Next raster position: h wraps at the end of the line and carries into
   // v, which in turn wraps at the end of the frame.
   always_comb begin
      h_next = (h == H_LAST) ? '0 : h + 1'b1;
      v_next = v;
      if (h == H_LAST) begin
         v_next = (v == V_LAST) ? '0 : v + 1'b1;
      end
   end

   assign de_c    = (h < H_ACT) && (v < V_ACT);
   assign hs_c    = (h >= HS_START) && (h < HS_END);
   assign vs_c    = (v >= VS_START) && (v < VS_END);
   assign fs_c    = (h == '0) && (v == '0);
   assign win_h   = (h >= X_START) && (h < X_END);
   assign win_v   = (v >= Y_START) && (v < Y_END);
   assign fetch_c = (h == FETCH_H) && win_v && (y_sub == '0);

   // The x phase only paces src_x; nothing downstream needs it directly.
   assign unused_x_sub = ^x_sub;

   // Raster position; holds while enable is low.
   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         h <= '0;
         v <= '0;
      end else if (enable) begin
         h <= h_next;
         v <= v_next;
      end
   end

   // Horizontal source coordinate. Clearing on the edge that moves onto
   // X_OFFSET means the counter already reads 0 while h sits on X_OFFSET.
   scale3_counter #(
      .SRC_MAX (SRC_W - 1)
   ) u_scale_x (
      .clk_pixel (clk_pixel),
      .resetn    (resetn),
      .clear     (enable && (h_next == X_START)),
      .advance   (enable && win_h),
      .sub       (x_sub),
      .src       (x_src)
   );

   // Vertical source coordinate, cleared entering the first window line and
   // stepped once at the last column of every window line.
   scale3_counter #(
      .SRC_MAX (SRC_H - 1)
   ) u_scale_y (
      .clk_pixel (clk_pixel),
      .resetn    (resetn),
      .clear     (enable && (h_next == '0) && (v_next == Y_START)),
      .advance   (enable && (h == H_LAST) && win_v),
      .sub       (y_sub),
      .src       (y_src)
   );

   // Output register stage. All outputs sample the current position so they
   // stay mutually aligned; while disabled the strobes drop to 0 and the
   // coordinates keep showing the held position.
   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         hcnt        <= '0;
         vcnt        <= '0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         de          <= 1'b0;
         frame_start <= 1'b0;
         win         <= 1'b0;
         src_x       <= '0;
         src_y       <= '0;
         fetch       <= 1'b0;
         fetch_y     <= '0;
      end else begin
         hcnt        <= h;
         vcnt        <= v;
         hsync       <= enable && hs_c;
         vsync       <= enable && vs_c;
         de          <= enable && de_c;
         frame_start <= enable && fs_c;
         win         <= enable && win_h && win_v;
         src_x       <= x_src;
         src_y       <= y_src;
         fetch       <= enable && fetch_c;
         fetch_y     <= y_src;
      end
   end

endmodule

// File: tb/tb_hdmi_timing_720p.sv
// Self-checking bench for hdmi_timing_720p.
//
// dut_a runs the real 720p geometry from reset through the first window
// lines and is checked against a table of raster positions. dut_b uses a
// shrunken geometry so whole frames, an enable pause and a mid-frame reset
// fit in a short run; it is checked every cycle against a raster model via
// a scoreboard queue.
module tb_hdmi_timing_720p;

   // Shrunken geometry for dut_b.
   localparam int B_H_ACTIVE = 40;
   localparam int B_H_FP     = 4;
   localparam int B_H_SYNC   = 3;
   localparam int B_H_BP     = 5;
   localparam int B_H_TOTAL  = 52;
   localparam int B_V_ACTIVE = 30;
   localparam int B_V_FP     = 2;
   localparam int B_V_SYNC   = 2;
   localparam int B_V_BP     = 3;
   localparam int B_V_TOTAL  = 37;
   localparam int B_X_OFF    = 10;
   localparam int B_Y_OFF    = 3;
   localparam int B_SRC_W    = 8;
   localparam int B_SRC_H    = 6;
   localparam int B_PREFETCH = 4;
   localparam int B_FRAME    = 1924;

   localparam int A_H_TOTAL  = 1650;

   typedef struct packed {
      logic [10:0] hcnt;
      logic [9:0]  vcnt;
      logic        hsync;
      logic        vsync;
      logic        de;
      logic        frame_start;
      logic        win;
      logic [7:0]  src_x;
      logic [7:0]  src_y;
      logic        fetch;
      logic [7:0]  fetch_y;
   } out_t;

   typedef struct {
      int   h;
      int   v;
      out_t exp;
   } vec_t;

   logic clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   logic        a_resetn, a_enable;
   logic [10:0] a_hcnt;
   logic [9:0]  a_vcnt;
   logic        a_hsync, a_vsync, a_de, a_frame_start, a_win, a_fetch;
   logic [7:0]  a_src_x, a_src_y, a_fetch_y;

   logic        b_resetn, b_enable;
   logic [10:0] b_hcnt;
   logic [9:0]  b_vcnt;
   logic        b_hsync, b_vsync, b_de, b_frame_start, b_win, b_fetch;
   logic [7:0]  b_src_x, b_src_y, b_fetch_y;

   hdmi_timing_720p dut_a (
      .clk_pixel   (clk_pixel),
      .resetn      (a_resetn),
      .enable      (a_enable),
      .hcnt        (a_hcnt),
      .vcnt        (a_vcnt),
      .hsync       (a_hsync),
      .vsync       (a_vsync),
      .de          (a_de),
      .frame_start (a_frame_start),
      .win         (a_win),
      .src_x       (a_src_x),
      .src_y       (a_src_y),
      .fetch       (a_fetch),
      .fetch_y     (a_fetch_y)
   );

   hdmi_timing_720p #(
      .H_ACTIVE (B_H_ACTIVE), .H_FP (B_H_FP), .H_SYNC (B_H_SYNC), .H_BP (B_H_BP),
      .V_ACTIVE (B_V_ACTIVE), .V_FP (B_V_FP), .V_SYNC (B_V_SYNC), .V_BP (B_V_BP),
      .X_OFFSET (B_X_OFF), .Y_OFFSET (B_Y_OFF), .SRC_W (B_SRC_W), .SRC_H (B_SRC_H),
      .PREFETCH (B_PREFETCH)
   ) dut_b (
      .clk_pixel   (clk_pixel),
      .resetn      (b_resetn),
      .enable      (b_enable),
      .hcnt        (b_hcnt),
      .vcnt        (b_vcnt),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .de          (b_de),
      .frame_start (b_frame_start),
      .win         (b_win),
      .src_x       (b_src_x),
      .src_y       (b_src_y),
      .fetch       (b_fetch),
      .fetch_y     (b_fetch_y)
   );

   int errors = 0;
   int checks = 0;

   // dut_b scoreboard and model state
   out_t sb_q[$];
   int   mh = 0;
   int   mv = 0;
   int   b_have_fs = 0;
   int   b_since = 0;
   int   b_de_cnt = 0;
   int   b_fetch_cnt = 0;
   int   b_hs_cnt = 0;
   int   b_vs_cnt = 0;
   int   b_expect_len = B_FRAME;
   int   b_saw_fs = 0;

   vec_t a_vecs[23];

   function automatic out_t sample_a();
      out_t o;
      o = '{a_hcnt, a_vcnt, a_hsync, a_vsync, a_de, a_frame_start, a_win,
            a_src_x, a_src_y, a_fetch, a_fetch_y};
      return o;
   endfunction

   function automatic out_t sample_b();
      out_t o;
      o = '{b_hcnt, b_vcnt, b_hsync, b_vsync, b_de, b_frame_start, b_win,
            b_src_x, b_src_y, b_fetch, b_fetch_y};
      return o;
   endfunction

   function automatic vec_t mk(int h, int v, logic hs, logic vs, logic de_e,
                               logic fs, logic w, int sx, int sy, logic f, int fy);
      vec_t r;
      r.h = h;
      r.v = v;
      r.exp = '0;
      r.exp.hcnt = 11'(h);
      r.exp.vcnt = 10'(v);
      r.exp.hsync = hs;
      r.exp.vsync = vs;
      r.exp.de = de_e;
      r.exp.frame_start = fs;
      r.exp.win = w;
      r.exp.src_x = 8'(sx);
      r.exp.src_y = 8'(sy);
      r.exp.fetch = f;
      r.exp.fetch_y = 8'(fy);
      return r;
   endfunction

   // Raster model for dut_b, written from the window/sync definitions.
   function automatic out_t model_b(int h, int v);
      out_t e;
      logic win_v;
      e = '0;
      win_v = (v >= B_Y_OFF) && (v < B_Y_OFF + 3 * B_SRC_H);
      e.hcnt = 11'(h);
      e.vcnt = 10'(v);
      e.de = (h < B_H_ACTIVE) && (v < B_V_ACTIVE);
      e.hsync = (h >= B_H_ACTIVE + B_H_FP) && (h < B_H_ACTIVE + B_H_FP + B_H_SYNC);
      e.vsync = (v >= B_V_ACTIVE + B_V_FP) && (v < B_V_ACTIVE + B_V_FP + B_V_SYNC);
      e.frame_start = (h == 0) && (v == 0);
      e.win = (h >= B_X_OFF) && (h < B_X_OFF + 3 * B_SRC_W) && win_v;
      if (e.win) begin
         e.src_x = 8'((h - B_X_OFF) / 3);
         e.src_y = 8'((v - B_Y_OFF) / 3);
      end
      e.fetch = (h == B_X_OFF - B_PREFETCH) && win_v && (((v - B_Y_OFF) % 3) == 0);
      if (e.fetch) e.fetch_y = 8'((v - B_Y_OFF) / 3);
      return e;
   endfunction

   task automatic checkValue(string name, int actual, int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Source coordinates only matter inside the window, fetch_y only with fetch.
   task automatic checkOutput(string name, out_t act, out_t exp);
      logic bad;
      bad = (act.hcnt != exp.hcnt) || (act.vcnt != exp.vcnt) ||
            (act.hsync != exp.hsync) || (act.vsync != exp.vsync) ||
            (act.de != exp.de) || (act.frame_start != exp.frame_start) ||
            (act.win != exp.win) || (act.fetch != exp.fetch) ||
            (exp.win && ((act.src_x != exp.src_x) || (act.src_y != exp.src_y))) ||
            (exp.fetch && (act.fetch_y != exp.fetch_y));
      checks++;
      if (bad) begin
         errors++;
         $display("[TB] FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b de=%0b fs=%0b win=%0b sx=%0d sy=%0d f=%0b fy=%0d, expected h=%0d v=%0d hs=%0b vs=%0b de=%0b fs=%0b win=%0b sx=%0d sy=%0d f=%0b fy=%0d",
                  name, act.hcnt, act.vcnt, act.hsync, act.vsync, act.de, act.frame_start,
                  act.win, act.src_x, act.src_y, act.fetch, act.fetch_y,
                  exp.hcnt, exp.vcnt, exp.hsync, exp.vsync, exp.de, exp.frame_start,
                  exp.win, exp.src_x, exp.src_y, exp.fetch, exp.fetch_y);
      end
   endtask

   // One dut_b cycle: drive enable, push the expectation, compare after the
   // edge, and keep per-frame statistics. Called at a falling edge and
   // returns at the next falling edge.
   task automatic applyStimulus(logic en);
      out_t e;
      out_t act;
      b_enable = en;
      if (en) begin
         e = model_b(mh, mv);
         mh++;
         if (mh == B_H_TOTAL) begin
            mh = 0;
            mv++;
            if (mv == B_V_TOTAL) mv = 0;
         end
      end else begin
         e = '0;
         e.hcnt = 11'(mh);
         e.vcnt = 10'(mv);
      end
      sb_q.push_back(e);
      @(posedge clk_pixel);
      #1;
      act = sample_b();
      e = sb_q.pop_front();
      checkOutput("sb_cycle", act, e);
      if (act.frame_start) begin
         b_saw_fs = 1;
         if (b_have_fs != 0) begin
            checkValue("frame_len", b_since, b_expect_len);
            checkValue("frame_de", b_de_cnt, B_H_ACTIVE * B_V_ACTIVE);
            checkValue("frame_fetch", b_fetch_cnt, B_SRC_H);
            checkValue("frame_hsync", b_hs_cnt, B_H_SYNC * B_V_TOTAL);
            checkValue("frame_vsync", b_vs_cnt, B_V_SYNC * B_H_TOTAL);
         end
         b_have_fs = 1;
         b_since = 0;
         b_de_cnt = 0;
         b_fetch_cnt = 0;
         b_hs_cnt = 0;
         b_vs_cnt = 0;
      end
      b_since++;
      if (act.de) b_de_cnt++;
      if (act.fetch) b_fetch_cnt++;
      if (act.hsync) b_hs_cnt++;
      if (act.vsync) b_vs_cnt++;
      @(negedge clk_pixel);
   endtask

   initial begin
      int cyc;
      int win24;
      int a_fetches;
      int guard;

      a_vecs[0]  = mk(0,    0,  0, 0, 1, 1, 0, 0,   0, 0, 0);
      a_vecs[1]  = mk(1279, 0,  0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[2]  = mk(1280, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[3]  = mk(1389, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[4]  = mk(1390, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[5]  = mk(1429, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[6]  = mk(1430, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[7]  = mk(1649, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0);
      a_vecs[8]  = mk(0,    1,  0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[9]  = mk(256,  23, 0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[10] = mk(240,  24, 0, 0, 1, 0, 0, 0,   0, 1, 0);
      a_vecs[11] = mk(241,  24, 0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[12] = mk(255,  24, 0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[13] = mk(256,  24, 0, 0, 1, 0, 1, 0,   0, 0, 0);
      a_vecs[14] = mk(258,  24, 0, 0, 1, 0, 1, 0,   0, 0, 0);
      a_vecs[15] = mk(259,  24, 0, 0, 1, 0, 1, 1,   0, 0, 0);
      a_vecs[16] = mk(1021, 24, 0, 0, 1, 0, 1, 255, 0, 0, 0);
      a_vecs[17] = mk(1023, 24, 0, 0, 1, 0, 1, 255, 0, 0, 0);
      a_vecs[18] = mk(1024, 24, 0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[19] = mk(240,  25, 0, 0, 1, 0, 0, 0,   0, 0, 0);
      a_vecs[20] = mk(256,  25, 0, 0, 1, 0, 1, 0,   0, 0, 0);
      a_vecs[21] = mk(240,  27, 0, 0, 1, 0, 0, 0,   0, 1, 1);
      a_vecs[22] = mk(259,  27, 0, 0, 1, 0, 1, 1,   1, 0, 0);

      a_resetn = 1'b0;
      a_enable = 1'b1;
      b_resetn = 1'b0;
      b_enable = 1'b0;

      repeat (3) @(negedge clk_pixel);
      checkOutput("a_reset", sample_a(), '0);
      checkOutput("b_reset", sample_b(), '0);

      // ---- dut_a: real 720p geometry, table of positions ----
      a_resetn = 1'b1;
      cyc = 0;
      win24 = 0;
      a_fetches = 0;
      for (int i = 0; i < 23; i++) begin
         int target;
         target = a_vecs[i].v * A_H_TOTAL + a_vecs[i].h;
         while (cyc <= target) begin
            @(posedge clk_pixel);
            #1;
            if ((cyc / A_H_TOTAL) == 24 && a_win) win24++;
            if (a_fetch) a_fetches++;
            if (cyc == target) checkOutput($sformatf("a_vec%0d", i), sample_a(), a_vecs[i].exp);
            cyc++;
         end
      end
      checkValue("a_win_line24", win24, 768);
      checkValue("a_fetch_count", a_fetches, 2);

      // ---- dut_b: whole frames against the scoreboard ----
      @(negedge clk_pixel);
      b_resetn = 1'b1;
      mh = 0;
      mv = 0;
      applyStimulus(1'b1);
      checkValue("b_first_fs", int'(b_frame_start), 1);
      checkValue("b_first_de", int'(b_de), 1);
      repeat (B_FRAME + 1) applyStimulus(1'b1);

      guard = 0;
      while (!(mh == 20 && mv == 15) && guard < 3000) begin
         applyStimulus(1'b1);
         guard++;
      end
      checkValue("b_reach_pause", guard < 3000 ? 1 : 0, 1);

      // Pause for 100 cycles; the frame containing it is 100 cycles longer.
      b_expect_len = B_FRAME + 100;
      repeat (100) applyStimulus(1'b0);
      checkValue("pause_de", int'(b_de), 0);
      checkValue("pause_hcnt", int'(b_hcnt), 20);
      applyStimulus(1'b1);
      checkValue("resume_de", int'(b_de), 1);
      checkValue("resume_hcnt", int'(b_hcnt), 20);

      b_saw_fs = 0;
      guard = 0;
      while (b_saw_fs == 0 && guard < 3000) begin
         applyStimulus(1'b1);
         guard++;
      end
      checkValue("pause_frame_seen", b_saw_fs, 1);
      b_expect_len = B_FRAME;

      guard = 0;
      while (!(mh == 30 && mv == 25) && guard < 3000) begin
         applyStimulus(1'b1);
         guard++;
      end
      checkValue("b_reach_reset", guard < 3000 ? 1 : 0, 1);

      // Mid-frame asynchronous reset: outputs drop without a clock edge.
      #2;
      b_resetn = 1'b0;
      #1;
      checkOutput("reset_async", sample_b(), '0);
      @(posedge clk_pixel);
      #1;
      checkOutput("reset_hold", sample_b(), '0);
      @(negedge clk_pixel);
      b_resetn = 1'b1;
      mh = 0;
      mv = 0;
      b_have_fs = 0;
      applyStimulus(1'b1);
      checkValue("restart_fs", int'(b_frame_start), 1);
      checkValue("restart_hcnt", int'(b_hcnt), 0);
      checkValue("restart_vcnt", int'(b_vcnt), 0);
      repeat (120) applyStimulus(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
